// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A one-bit index is still needed when there are only one or two channels.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: first set req bit at or after ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load enable.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] gnt_dbl;
    logic [NUM_CH-1:0]   rot;
    logic [NUM_CH-1:0]   rot_gnt;
    logic                found;

    always_comb begin
        req_dbl = {req, req};
        // Rotating the doubled vector puts channel ptr at bit 0, so a plain
        // lowest-set-bit scan gives the wrap-around priority order.
        rot     = NUM_CH'(req_dbl >> ptr);
        rot_gnt = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rot[i] && !found) begin
                rot_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt_dbl = {{NUM_CH{1'b0}}, rot_gnt} << ptr;
        grant   = gnt_dbl[NUM_CH-1:0] | gnt_dbl[2*NUM_CH-1:NUM_CH];
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// N:1 valid/ready stream mux, fixed-select or round-robin, with a registered output.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle with out_ready high.
// Backpressure: a held output word blocks every in_ready until the consumer drains it.
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_chan
);

    logic              load_en;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  ptr_nxt;
    logic [NUM_CH-1:0] rr_gnt;
    logic [NUM_CH-1:0] fix_gnt;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] xfer_vec;
    logic              xfer;
    logic [SEL_W-1:0]  xfer_idx;
    logic [DATA_W-1:0] xfer_dat;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (SEL_W)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_gnt)
    );

    always_comb begin
        load_en = !out_valid || out_ready;

        // An out-of-range sel matches no channel, so it yields no grant.
        fix_gnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            fix_gnt[i] = in_valid[i] && (sel == SEL_W'(i));
        end

        grant    = (mode == MODE_RR) ? rr_gnt : fix_gnt;
        in_ready = (rst_n && load_en) ? grant : '0;
        xfer_vec = in_valid & in_ready;
        xfer     = |xfer_vec;

        xfer_idx = '0;
        xfer_dat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (xfer_vec[i]) begin
                xfer_idx = xfer_idx | SEL_W'(i);
                xfer_dat = xfer_dat | in_data[i*DATA_W +: DATA_W];
            end
        end

        ptr_nxt = (xfer_idx == SEL_W'(NUM_CH - 1)) ? '0 : xfer_idx + SEL_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= xfer_dat;
                out_chan <= xfer_idx;
                if (mode == MODE_RR) begin
                    rr_ptr <= ptr_nxt;
                end
            end
        end
    end

endmodule
